// File: rtl/key_debounce_pkg.sv
// Shared constants and helpers for the key/switch conditioning block.
// Holds synchroniser depth, default parameter values and counter sizing.
package key_debounce_pkg;

    // Number of flops in every per-channel input synchroniser.
    localparam int SYNC_DEPTH = 2;

    // Default parameter values.
    localparam int DEF_SYSCLK_FREQ  = 1000;
    localparam int DEF_CHANNELS     = 14;
    localparam int DEF_DEBOUNCE_MS  = 10;
    localparam int DEF_RPT_DELAY_MS = 500;
    localparam int DEF_RPT_RATE_MS  = 100;

    // Clock cycles per millisecond; sysclk_frequency is in 100 kHz units.
    function automatic int ms_ticks(input int sysclk_frequency);
        return sysclk_frequency * 100;
    endfunction

    // Bits needed for a counter that must hold max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One input channel: synchroniser, polarity fix, ms debounce counter and
// level/pressed/released registers.
// Ports: clk, reset (async, active-high), raw_i (pin), tick_i (1 ms strobe),
//        level_o, pressed_o, released_o.
// Optional auto-repeat when KEY_DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int   DEBOUNCE_MS = DEF_DEBOUNCE_MS,
    parameter logic INV         = 1'b0
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int   REPEAT_DELAY_MS = DEF_RPT_DELAY_MS,
    parameter int   REPEAT_RATE_MS  = DEF_RPT_RATE_MS
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    input  logic tick_i,
    output logic level_o,
    output logic pressed_o,
    output logic released_o
);

    localparam int               CNT_W   = cnt_width(DEBOUNCE_MS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_MS);

    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  level_q, level_d;
    logic                  pressed_q, pressed_d;
    logic                  released_q, released_d;
    logic                  s;
    logic                  acc_press, acc_release;

    assign s = sync_q[SYNC_DEPTH-1] ^ INV;

    // The counter only advances on ticks, and acceptance happens on the tick
    // after it reached DEBOUNCE_MS, so the input has been stable for a full
    // DEBOUNCE_MS ms (plus up to one partial ms) when level moves.
    always_comb begin
        sync_d      = {sync_q[SYNC_DEPTH-2:0], raw_i};
        cnt_d       = cnt_q;
        level_d     = level_q;
        acc_press   = 1'b0;
        acc_release = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_MAX) begin
                level_d     = s;
                cnt_d       = '0;
                acc_press   = s;
                acc_release = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int RPT_MAX_I = REPEAT_DELAY_MS + REPEAT_RATE_MS;
    localparam int RPT_W     = cnt_width(RPT_MAX_I);
    localparam logic [RPT_W-1:0] RPT_MAX   = RPT_W'(RPT_MAX_I);
    localparam logic [RPT_W-1:0] RPT_DELAY = RPT_W'(REPEAT_DELAY_MS);

    logic [RPT_W-1:0] rpt_q, rpt_d, rpt_nxt;
    logic             rpt_hit;

    // Counts ms while the key stays held; folds back to the delay value
    // after each rate period so it never needs to grow past RPT_MAX.
    always_comb begin
        rpt_d   = rpt_q;
        rpt_hit = 1'b0;
        rpt_nxt = rpt_q + 1'b1;
        if (!level_d) begin
            rpt_d = '0;
        end else if (level_q && tick_i) begin
            if (rpt_nxt == RPT_MAX) begin
                rpt_d   = RPT_DELAY;
                rpt_hit = 1'b1;
            end else begin
                rpt_d   = rpt_nxt;
                rpt_hit = (rpt_nxt == RPT_DELAY);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end

    assign pressed_d = acc_press | rpt_hit;
`else
    assign pressed_d = acc_press;
`endif

    assign released_d = acc_release;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= {SYNC_DEPTH{INV}};
            cnt_q      <= '0;
            level_q    <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign level_o    = level_q;
    assign pressed_o  = pressed_q;
    assign released_o = released_q;

endmodule

// File: rtl/key_debounce.sv
// Board input conditioner: shared 1 ms prescaler plus one debounce_channel
// per raw input.
// Ports: clk, reset (async, active-high), raw[channels] pins in;
//        level/pressed/released[channels] out, tick_1ms strobe out.
// Macro KEY_DEBOUNCE_AUTOREPEAT_EN adds auto-repeat pressed pulses.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int                  sysclk_frequency = DEF_SYSCLK_FREQ,
    parameter int                  channels         = DEF_CHANNELS,
    parameter logic [channels-1:0] inv_mask         = channels'(14'h000F),
    parameter int                  debounce_ms      = DEF_DEBOUNCE_MS
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int                  repeat_delay_ms  = DEF_RPT_DELAY_MS,
    parameter int                  repeat_rate_ms   = DEF_RPT_RATE_MS
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [channels-1:0] raw,
    output logic [channels-1:0] level,
    output logic [channels-1:0] pressed,
    output logic [channels-1:0] released,
    output logic                tick_1ms
);

    localparam int               PRE_CYC = ms_ticks(sysclk_frequency);
    localparam int               PRE_W   = cnt_width(PRE_CYC - 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_CYC - 1);

    logic [PRE_W-1:0] pre_q, pre_d;

    assign tick_1ms = (pre_q == PRE_MAX);

    always_comb begin
        pre_d = pre_q + 1'b1;
        if (tick_1ms) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar i = 0; i < channels; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_MS     (debounce_ms),
            .INV             (inv_mask[i])
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY_MS (repeat_delay_ms),
            .REPEAT_RATE_MS  (repeat_rate_ms)
`endif
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .raw_i      (raw[i]),
            .tick_i     (tick_1ms),
            .level_o    (level[i]),
            .pressed_o  (pressed[i]),
            .released_o (released[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with a tick every 100 clk and a
// 3 ms debounce; a timing model is checked every cycle plus literal checks.
module tb_key_debounce;

    localparam int CH  = 14;
    localparam int DB  = 3;
    localparam int PER = 100;
    localparam logic [CH-1:0] INV = 14'h000F;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int RD = 5;
    localparam int RR = 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] raw;
    logic [CH-1:0] level, pressed, released;
    logic          tick_1ms;

    int vecs = 0;
    int errs = 0;
    int now  = 0;
    int prs_cnt[CH];
    int rel_cnt[CH];

    always #5 clk = ~clk;

    key_debounce #(
        .sysclk_frequency (1),
        .channels         (CH),
        .inv_mask         (INV),
        .debounce_ms      (DB)
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        ,
        .repeat_delay_ms  (RD),
        .repeat_rate_ms   (RR)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .raw      (raw),
        .level    (level),
        .pressed  (pressed),
        .released (released),
        .tick_1ms (tick_1ms)
    );

    // ---------------- reference model ----------------
    // Ticks land on cycles n with n%PER==PER-1 (n = edges since reset).
    // A change is accepted on the tick that is the (DB+1)th tick seen
    // while the synchronised input has continuously differed from level.
    int            n;
    logic [CH-1:0] rhist [2];
    logic [CH-1:0] m_lvl, m_prs, m_rel;
    logic          m_tick;
    int            dstart [CH];
    bit            div [CH];
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    int            ms_up [CH];
`endif

    function automatic int ticks_in(input int a, input int b);
        return (b + 1) / PER - a / PER;
    endfunction

    always @(posedge clk or posedge reset) begin
        bit            tk;
        bit            prev;
        logic [CH-1:0] s;
        if (reset) begin
            n        = 0;
            rhist[0] = INV;
            rhist[1] = INV;
            m_lvl    = '0;
            m_prs    = '0;
            m_rel    = '0;
            m_tick   = 1'b0;
            for (int c = 0; c < CH; c++) begin
                div[c]    = 1'b0;
                dstart[c] = 0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                ms_up[c]  = 0;
`endif
            end
        end else begin
            tk    = ((n % PER) == PER - 1);
            s     = rhist[1] ^ INV;
            m_prs = '0;
            m_rel = '0;
            for (int c = 0; c < CH; c++) begin
                prev = m_lvl[c];
                if (s[c] == m_lvl[c]) begin
                    div[c] = 1'b0;
                end else begin
                    if (!div[c]) begin
                        div[c]    = 1'b1;
                        dstart[c] = n;
                    end
                    if (tk && ticks_in(dstart[c], n) == DB + 1) begin
                        m_lvl[c] = s[c];
                        div[c]   = 1'b0;
                        if (s[c]) m_prs[c] = 1'b1;
                        else      m_rel[c] = 1'b1;
                    end
                end
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                if (!m_lvl[c]) begin
                    ms_up[c] = 0;
                end else if (prev && tk) begin
                    ms_up[c]++;
                    if (ms_up[c] == RD ||
                        (ms_up[c] > RD && (ms_up[c] - RD) % RR == 0))
                        m_prs[c] = 1'b1;
                end
`else
                if (prev && 1'b0) m_prs[c] = 1'b1;
`endif
            end
            rhist[1] = rhist[0];
            rhist[0] = raw;
            n++;
            m_tick = ((n % PER) == PER - 1);
        end
    end

    // ---------------- per-cycle compare + pulse monitor ----------------
    task automatic cmp(input string nm, input logic [CH-1:0] act,
                       input logic [CH-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL t=%0t %s: got %h want %h", $time, nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        now++;
        for (int c = 0; c < CH; c++) begin
            if (pressed[c] === 1'b1)  prs_cnt[c]++;
            if (released[c] === 1'b1) rel_cnt[c]++;
        end
        cmp("level", level, m_lvl);
        cmp("pressed", pressed, m_prs);
        cmp("released", released, m_rel);
        cmp("tick_1ms", {{(CH-1){1'b0}}, tick_1ms},
            {{(CH-1){1'b0}}, m_tick});
    end

    // ---------------- literal checks ----------------
    task automatic chk(input string nm, input int act,
                       input int lo, input int hi);
        vecs++;
        if (act < lo || act > hi) begin
            errs++;
            $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_lvl(input int c, input logic v, input int lim,
                            output int ts);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (level[c] === v) begin
                ts = now;
                return;
            end
        end
        ts = -100000;
    endtask

    initial begin
        int t0, ta, tb, p0, r0, p5, p1;
        for (int c = 0; c < CH; c++) begin
            prs_cnt[c] = 0;
            rel_cnt[c] = 0;
        end
        reset = 1'b1;
        raw   = INV;
        cyc(3);
        chk("reset_level", int'(level), 0, 0);
        chk("reset_pulses", int'(pressed | released), 0, 0);
        chk("reset_tick", int'(tick_1ms), 0, 0);
        reset = 1'b0;
        cyc(50);

        // clean press on active-low channel 0
        p0 = prs_cnt[0];
        r0 = rel_cnt[0];
        t0 = now;
        raw[0] = 1'b0;
        wait_lvl(0, 1'b1, 450, ta);
        chk("press_latency", ta - t0, 302, 402);
        cyc(10);
        chk("press_pulse_cnt", prs_cnt[0] - p0, 1, 1);
        chk("press_no_release", rel_cnt[0] - r0, 0, 0);

        // release
        p0 = prs_cnt[0];
        r0 = rel_cnt[0];
        t0 = now;
        raw[0] = 1'b1;
        wait_lvl(0, 1'b0, 450, ta);
        chk("release_latency", ta - t0, 302, 402);
        cyc(10);
        chk("release_pulse_cnt", rel_cnt[0] - r0, 1, 1);
        chk("release_no_press", prs_cnt[0] - p0, 0, 0);

        // bounce: toggle every 50 clk for 1000 clk, then hold pressed
        p0 = prs_cnt[0];
        r0 = rel_cnt[0];
        for (int i = 0; i < 20; i++) begin
            raw[0] = ~raw[0];
            cyc(50);
        end
        chk("bounce_no_press", prs_cnt[0] - p0, 0, 0);
        chk("bounce_no_release", rel_cnt[0] - r0, 0, 0);
        t0 = now;
        raw[0] = 1'b0;
        wait_lvl(0, 1'b1, 402, ta);
        chk("bounce_settle", ta - t0, 302, 402);
        cyc(5);
        chk("bounce_one_press", prs_cnt[0] - p0, 1, 1);

        // reset mid-debounce on active-high channel 5 (ch0 held pressed)
        raw[5] = 1'b1;
        cyc(200);
        reset = 1'b1;
        #1;
        chk("midrst_level", int'(level), 0, 0);
        chk("midrst_pulses", int'(pressed | released), 0, 0);
        @(negedge clk);
        reset = 1'b0;
        t0 = now;
        p0 = prs_cnt[0];
        p5 = prs_cnt[5];
        wait_lvl(5, 1'b1, 450, ta);
        chk("midrst_relatch", ta - t0, 302, 402);
        cyc(5);
        chk("midrst_ch5_press", prs_cnt[5] - p5, 1, 1);
        chk("held_at_reset_press", prs_cnt[0] - p0, 1, 1);

        // multi-channel: ch1 (active-low) and ch9 together, ch9 bounces
        p1 = prs_cnt[1];
        t0 = now;
        raw[1] = 1'b0;
        raw[9] = 1'b1;
        cyc(150);
        raw[9] = 1'b0;
        cyc(1);
        raw[9] = 1'b1;
        wait_lvl(1, 1'b1, 400, ta);
        chk("multi_ch1_latency", ta - t0, 302, 402);
        wait_lvl(9, 1'b1, 400, tb);
        chk("multi_ch9_delay", tb - ta, 100, 200);
        cyc(5);
        chk("multi_ch1_press", prs_cnt[1] - p1, 1, 1);

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        raw[2] = 1'b0;
        wait_lvl(2, 1'b1, 450, ta);
        p0 = prs_cnt[2];
        cyc(1000);
        chk("repeat_pulses", prs_cnt[2] - p0, 3, 3);
        raw[2] = 1'b1;
        wait_lvl(2, 1'b0, 450, ta);
        p0 = prs_cnt[2];
        cyc(600);
        chk("repeat_stop", prs_cnt[2] - p0, 0, 0);
`endif

        raw = INV;
        cyc(500);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
